mem_readback: RTL and testbench
===============================

Name: mem_readback

Overview:
- Sequential reader for the single-clock simple-dual-port block RAM used in the 72k designs. Default geometry is 8192 x 9.
- On a start pulse it walks a contiguous address range through the RAM read port and streams each word out on a valid/ready interface.
- It also accumulates a 16-bit additive checksum of the words read.
- Used to dump and verify RAM contents after bitstream memory re-initialisation. It sits between the RAM's raddr/dout pins and the host/debug stream.

Parameters:
- WID_MEM, 9, RAM word width in bits.
- DEPTH_MEM, 8192, RAM depth in words; must be a power of two.
- ADDR_W, 13, address width; equals log2(DEPTH_MEM).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset. Asserting (low) clears all state immediately. Deassertion is synchronised by the integrator.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on accepted start.
- count  in  ADDR_W+1  number of words to read, latched on accepted start; legal range 0..DEPTH_MEM.
- raddr  out  ADDR_W  RAM read address.
- rdata  in  WID_MEM  RAM dout; valid exactly one cycle after the address is presented (registered read).
- out_data  out  WID_MEM  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been accepted by the consumer.
- checksum  out  16  running sum; holds the final value after done until the next accepted start.

Behaviour:
- Reset values: raddr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0, FSM=IDLE, FIFO empty, no read in flight.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start:
  - latches base_addr and count;
  - clears checksum;
  - sets issue counter = count.
  - If count==0, go directly to DONE instead.
- RUN, read issue: each issue cycle presents raddr = current address, marks one read in flight, increments the address, and decrements the remaining-issue counter.
- Address arithmetic: the address increments modulo DEPTH_MEM. base_addr=DEPTH_MEM-1 followed by one more read gives address 0 (wrap, no error).
- Output buffer: a 2-entry FIFO. The returning rdata is written into it the cycle after issue.
- Issue condition: issue is allowed only when (FIFO occupancy + reads in flight − pop this cycle) < 2. The FIFO therefore never overflows under any out_ready pattern. With out_ready held high, throughput is one word per cycle.
- RUN -> DRAIN once the remaining-issue counter reaches 0.
- DRAIN -> DONE when the FIFO is empty and no read is in flight.
- DONE: pulses done for one cycle, deasserts busy, returns to IDLE.
- Stream rules:
  - out_valid equals FIFO non-empty; out_data is the FIFO head.
  - Once out_valid rises, out_data is held stable until accepted.
- Checksum: on every accepted stream word, checksum = (checksum + zero-extended out_data) mod 2^16.
- Latency: with out_ready=1 throughout, the first out_valid appears 2 cycles after start is sampled. done appears 1 cycle after the last acceptance.
- start while busy or in DONE: ignored; the parameters of the current job are unchanged.
- count == DEPTH_MEM: reads every word exactly once, ending at base_addr−1 (mod DEPTH_MEM).
- Reset mid-operation: everything returns to reset values at once. An in-flight rdata is discarded and no done pulse is produced.
- raddr when not issuing: holds its last value; the RAM read is harmless.

Test Plan:
- RAM preloaded with word[i] = i mod 512. Start with base=0, count=4, out_ready=1:
  - outputs 0,1,2,3 on consecutive cycles;
  - first out_valid 2 cycles after start;
  - done 1 cycle after the last word;
  - checksum=6.
- Start with base=8190, count=4: raddr sequence 8190, 8191, 0, 1; data 510, 511, 0, 1; checksum=1022.
- base=0, count=8, out_ready toggled 1,0,0,1,0,1,...:
  - all 8 words delivered in order with none dropped or duplicated;
  - out_data stable while out_valid & !out_ready;
  - reads in flight + occupancy never exceed 2.
- count=0: done pulses with busy low 1 cycle after start; checksum=0; no stream output.
- A second start asserted in the cycle after the first (base=100, count=3): ignored; only the first job's 3 words appear.
- reset driven low while 2 words are buffered: out_valid, busy and checksum go to 0 immediately. After release, a new start with base=5, count=1 outputs word 5 and gives checksum=5.

Source files
------------

// File: rtl/mem_readback.sv
// Sequential block-RAM reader: walks an address range, streams words over valid/ready
// through a 2-entry skid FIFO and accumulates a 16-bit additive checksum.
module mem_readback #(
  parameter int WID_MEM   = 9,
  parameter int DEPTH_MEM = 8192,
  parameter int ADDR_W    = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    count,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] rdata,
  output logic [WID_MEM-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        checksum
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing reads while the FIFO has room
  // DRAIN | all reads issued, emptying in-flight read and FIFO
  // DONE  | one-cycle done pulse, back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [WID_MEM-1:0]  head_q, head_d;
  logic [WID_MEM-1:0]  tail_q, tail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         chk_q, chk_d;

  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occ;
  logic [15:0]         head_ext;

  always_comb begin
    pop      = (fifo_cnt_q != 2'd0) && out_ready;
    push     = inflight_q;
    // Slots committed for next cycle; pop only happens with a non-empty FIFO.
    occ      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = (state_q == S_RUN) && (remain_q != '0) && (occ < 3'd2);
    raddr    = issue ? addr_q : raddr_q;
    head_ext = 16'(head_q);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    raddr_d    = raddr_q;
    inflight_d = issue;
    fifo_cnt_d = fifo_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    chk_d      = chk_q;

    case ({push, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) head_d = rdata;
        else                    tail_d = rdata;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          head_d = rdata;
        end else begin
          head_d = tail_q;
          tail_d = rdata;
        end
      end
      default: ;
    endcase

    if (pop) chk_d = chk_q + head_ext;

    if (issue) begin
      raddr_d  = addr_q;
      addr_d   = (addr_q == ADDR_W'(DEPTH_MEM - 1)) ? '0 : addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = count;
          chk_d    = '0;
          if (count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (remain_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((fifo_cnt_d == 2'd0) && !inflight_d) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      chk_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      raddr_q    <= raddr_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      chk_q      <= chk_d;
    end
  end

  assign out_data  = head_q;
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = chk_q;

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback with a behavioural registered-read RAM preloaded i mod 512.
module tb_mem_readback;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] count;
  logic [12:0] raddr;
  logic [8:0]  rdata;
  logic [8:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  int ncmp = 0;
  int nerr = 0;

  logic [8:0] mem [0:8191];

  mem_readback #(.WID_MEM(9), .DEPTH_MEM(8192), .ADDR_W(13)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 9'(i % 512);
  end

  always @(posedge clk) rdata <= mem[raddr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_start(input int b, input int c);
    base_addr = 13'(b);
    count     = 14'(c);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  logic [0:11] rpat;
  int          nw;
  int          got_done;
  logic        held_v;
  logic [8:0]  held_d;
  int          a2 [0:3];
  int          d2 [0:3];

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
    #12;
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_data", out_data, 0);
    #8 reset = 1'b1;
    tick();

    // Job 1: base 0, count 4, always ready
    out_ready = 1'b1;
    do_start(0, 4);
    chk("t1_busy", busy, 1);
    chk("t1_valid_c1", out_valid, 0);
    chk("t1_raddr0", raddr, 0);
    tick();
    chk("t1_valid_c2", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, k);
      chk("t1_nodone", done, 0);
    end
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_valid_low", out_valid, 0);
    chk("t1_checksum", checksum, 6);
    tick();
    chk("t1_done_pulse", done, 0);

    // Job 2: address wrap
    a2 = '{8190, 8191, 0, 1};
    d2 = '{510, 511, 0, 1};
    do_start(8190, 4);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) chk("t2_raddr", raddr, a2[k]);
      if (k >= 2) begin
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, d2[k-2]);
      end
      tick();
    end
    chk("t2_done", done, 1);
    chk("t2_checksum", checksum, 1022);
    tick();

    // Job 3: backpressure pattern
    rpat = 12'b100101101001;
    out_ready = 1'b0;
    do_start(0, 8);
    nw = 0; got_done = 0; held_v = 1'b0; held_d = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      out_ready = rpat[cyc % 12];
      chk("t3_occ_le2", int'((32'(dut.fifo_cnt_q) + 32'(dut.inflight_q)) <= 2), 1);
      if (held_v) begin
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_data", out_data, held_d);
      end
      if (out_valid && out_ready) begin
        chk("t3_word", out_data, nw);
        nw++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      tick();
    end
    chk("t3_got_done", got_done, 1);
    chk("t3_nwords", nw, 8);
    chk("t3_checksum", checksum, 28);
    out_ready = 1'b1;
    tick();

    // Job 4: zero count
    do_start(77, 0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", out_valid, 0);
    chk("t4_checksum", checksum, 0);
    tick();
    chk("t4_done_pulse", done, 0);
    chk("t4_valid2", out_valid, 0);

    // Job 5: second start during busy is ignored
    do_start(100, 3);
    do_start(200, 5);
    nw = 0; got_done = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (out_valid) begin
        chk("t5_word", out_data, 100 + nw);
        nw++;
      end
      tick();
    end
    chk("t5_got_done", got_done, 1);
    chk("t5_nwords", nw, 3);
    chk("t5_checksum", checksum, 303);
    tick();

    // Job 6: reset with two buffered words
    out_ready = 1'b0;
    do_start(10, 4);
    tick(); tick(); tick();
    out_ready = 1'b1;
    chk("t6_valid", out_valid, 1);
    chk("t6_head", out_data, 10);
    tick();
    out_ready = 1'b0;
    tick();
    chk("t6_valid2", out_valid, 1);
    chk("t6_head2", out_data, 11);
    chk("t6_sum_pre", checksum, 10);
    chk("t6_busy_pre", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_checksum", checksum, 0);
    chk("t6_rst_done", done, 0);
    #3 reset = 1'b1;
    tick();
    chk("t6_no_done", done, 0);
    out_ready = 1'b1;
    do_start(5, 1);
    tick();
    tick();
    chk("t6_new_valid", out_valid, 1);
    chk("t6_new_data", out_data, 5);
    tick();
    chk("t6_new_done", done, 1);
    chk("t6_new_checksum", checksum, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
